caxi4dma_rd_burst_master: RTL

// - AXI4 read-channel master for the DMA read path. Sits downstream of the read transaction controller.
// - Accepts one transfer request: start address, byte count, max beats per burst.
// - Splits it into INCR bursts that never cross a 4KB boundary and drives AR.
// - Streams R beats to the write-side buffer, then reports done or error.

---
 rtl/caxi4dma_rd_burst_master_if.sv | 34 +++
 rtl/caxi4dma_rd_burst_master.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/caxi4dma_rd_burst_master_if.sv
// AXI4 read-address / read-data channel bundle for the DMA read burst master.
// The master modport belongs to the burst master; the slave modport is the memory side.
interface caxi4dma_rd_burst_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]   ARID;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/caxi4dma_rd_burst_master.sv
// AXI4 read burst master for the DMA read path.
// Splits one transfer request into INCR bursts that never cross a 4KB page,
// caps bursts in flight at MAX_OUTSTANDING, and streams R beats straight to
// the write-side buffer with zero latency.
// Optional macro CAXI4DMA_RD_ERR_ABORT_EN: stop issuing AR after the first
// error response, drain what is in flight, then pulse err.
module caxi4dma_rd_burst_master #(
    parameter int                ADDR_WIDTH      = 32,
    parameter int                DATA_WIDTH      = 64,
    parameter int                BYTE_CNT_WIDTH  = 23,
    parameter int                ID_WIDTH        = 4,
    parameter logic [ID_WIDTH-1:0] ID_VALUE      = '0,
    parameter int                MAX_OUTSTANDING = 4
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    input  logic                      reqValid,
    output logic                      reqReady,
    input  logic [ADDR_WIDTH-1:0]     reqAddr,
    input  logic [BYTE_CNT_WIDTH-1:0] reqNumBytes,
    input  logic [7:0]                reqMaxBeats,
    caxi4dma_rd_burst_master_if.master axi,
    output logic [DATA_WIDTH-1:0]     dOut,
    output logic                      dOutValid,
    input  logic                      dOutReady,
    output logic                      dOutLast,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                errResp
);
    localparam int BPB     = DATA_WIDTH / 8;
    localparam int BPB_LOG = $clog2(BPB);
    // beat counters carry one spare bit so the round-up add cannot wrap
    localparam int CW      = BYTE_CNT_WIDTH + 1;

`ifdef CAXI4DMA_RD_ERR_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ADDR, S_WAIT, S_DONE} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CW-1:0]         issue_left, recv_left;
    logic [7:0]            maxb_q, arlen_q;
    logic [3:0]            outst;
    logic                  err_q, ar_pend;
    logic [1:0]            err_code;

    logic                  active, arvalid_c, ar_hs, r_hs, rlast_hs, stop_issue;
    logic [CW-1:0]         req_beats, bnd_beats, mb_beats, len_c, cur_beats;

    assign req_beats  = (CW'(reqNumBytes) + CW'(BPB - 1)) >> BPB_LOG;
    assign bnd_beats  = CW'(13'd4096 - {1'b0, addr_q[11:0]}) >> BPB_LOG;
    assign mb_beats   = CW'(maxb_q) + CW'(1);
    assign cur_beats  = CW'(arlen_q) + CW'(1);
    assign stop_issue = ABORT && err_q;

    // burst length: smallest of remaining beats, per-burst cap and beats to the 4KB page end
    always_comb begin
        len_c = issue_left;
        if (mb_beats < len_c)  len_c = mb_beats;
        if (bnd_beats < len_c) len_c = bnd_beats;
    end

    assign active   = (state == S_CALC) || (state == S_ADDR) || (state == S_WAIT);
    assign ar_hs    = arvalid_c && axi.ARREADY;
    assign r_hs     = axi.RVALID && axi.RREADY;
    assign rlast_hs = r_hs && axi.RLAST;

    assign reqReady    = (state == S_IDLE) && !RESET;
    assign axi.ARVALID = arvalid_c;
    assign axi.ARADDR  = addr_q;
    assign axi.ARLEN   = arlen_q;
    assign axi.ARSIZE  = 3'(BPB_LOG);
    assign axi.ARBURST = 2'b01;
    assign axi.ARID    = ID_VALUE;
    assign axi.RREADY  = active && dOutReady;
    assign dOut        = axi.RDATA;
    assign dOutValid   = active && axi.RVALID;
    assign dOutLast    = active && (recv_left == CW'(1)) && !stop_issue;
    assign done        = (state == S_DONE) && !err_q;
    assign err         = (state == S_DONE) && err_q;
    assign errResp     = err ? err_code : 2'b00;

    // state register
    always_ff @(posedge CLOCK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // next state and AR valid; once ARVALID is raised it stays up until accepted
    always_comb begin
        state_nxt = state;
        arvalid_c = 1'b0;
        case (state)
            S_IDLE: if (reqValid) state_nxt = (req_beats == '0) ? S_DONE : S_CALC;
            S_CALC: state_nxt = stop_issue ? S_WAIT : S_ADDR;
            S_ADDR: begin
                arvalid_c = ar_pend || ((outst < 4'(MAX_OUTSTANDING)) && !stop_issue);
                if (arvalid_c && axi.ARREADY)
                    state_nxt = (issue_left == cur_beats) ? S_WAIT : S_CALC;
                else if (!arvalid_c && stop_issue)
                    state_nxt = S_WAIT;
            end
            S_WAIT: if ((recv_left == '0) || (stop_issue && outst == '0)) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // request latch, burst address/length, beat and burst accounting, error capture
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            addr_q     <= '0;
            issue_left <= '0;
            recv_left  <= '0;
            maxb_q     <= '0;
            arlen_q    <= '0;
            outst      <= '0;
            err_q      <= 1'b0;
            err_code   <= 2'b00;
            ar_pend    <= 1'b0;
        end else begin
            ar_pend <= arvalid_c && !axi.ARREADY;
            if (state == S_IDLE && reqValid) begin
                addr_q     <= reqAddr;
                issue_left <= req_beats;
                recv_left  <= req_beats;
                maxb_q     <= reqMaxBeats;
                err_q      <= 1'b0;
                err_code   <= 2'b00;
            end
            if (state == S_CALC) arlen_q <= 8'(len_c - CW'(1));
            if (ar_hs) begin
                addr_q     <= addr_q + (ADDR_WIDTH'(cur_beats) << BPB_LOG);
                issue_left <= issue_left - cur_beats;
            end
            if (r_hs) recv_left <= recv_left - CW'(1);
            if (r_hs && axi.RRESP != 2'b00 && !err_q) begin
                err_q    <= 1'b1;
                err_code <= axi.RRESP;
            end
            case ({ar_hs, rlast_hs})
                2'b10:   outst <= outst + 4'd1;
                2'b01:   outst <= outst - 4'd1;
                default: outst <= outst;
            endcase
        end
    end
endmodule
